// File: rtl/pulpino_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulpino_rst_pkg
// Description : Shared types for the PULPino reset sequencer: FSM state
//               encoding, reset-cause encoding and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pulpino_rst_pkg;

  // Sequencer states; WAIT_LOCK is the reset state.
  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_HOLD_ALL   = 3'd1,
    ST_REL_PERIPH = 3'd2,
    ST_REL_CORE   = 3'd3,
    ST_RUN        = 3'd4
  } rst_state_e;

  // Cause of the most recent reset, readable by software.
  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_EXT  = 2'd1,
    CAUSE_LOCK = 2'd2,
    CAUSE_SW   = 2'd3
  } rst_cause_e;

  // Largest of four values, used to size the shared sequence counter.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : rst_sync_debounce
// Description : Multi-flop synchroniser for an asynchronous level, with an
//               optional debounce filter. CYCLES = 0 gives a plain
//               synchroniser; otherwise the output only changes after CYCLES
//               consecutive synchronised samples disagree with it.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sync_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CYCLES      = 0,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o
);

  logic                   arm_q;
  logic [SYNC_STAGES-1:0] sync_q;

  // Synchroniser chain. Sampling starts one cycle after reset release so the
  // first capture never coincides with the release edge itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arm_q  <= 1'b0;
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      arm_q <= 1'b1;
      if (arm_q) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      end
    end
  end

  generate
    if (CYCLES == 0) begin : g_sync_only
      assign level_o = sync_q[SYNC_STAGES-1];
    end else begin : g_debounce
      localparam int unsigned CW = $clog2(CYCLES + 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          level_q, level_d;

      // Count consecutive disagreeing samples; any agreeing sample clears.
      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[SYNC_STAGES-1] != level_q) begin
          if (cnt_q == CW'(CYCLES - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
      end

      // Debounce state registers.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q   <= '0;
          level_q <= RESET_VAL;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
        end
      end

      assign level_o = level_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pulpino_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : pulpino_rst_seq
// Description : PULPino reset sequencer. Synchronises/debounces board reset
//               and clock lock, then releases peripheral reset, core reset
//               and fetch-enable in a counted order. Records the last cause.
// Revision    : 1.0 - initial release
// ============================================================================
module pulpino_rst_seq
  import pulpino_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PERIPH_HOLD     = 32,
  parameter int unsigned CORE_DELAY      = 16,
  parameter int unsigned FETCH_DELAY     = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ext_rst_ni,
  input  logic       clk_locked_i,
  input  logic       sw_rst_req_i,
  output logic       rstn_periph_o,
  output logic       rstn_core_o,
  output logic       fetch_enable_o,
  output logic [1:0] rst_cause_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W =
    $clog2(max4(PERIPH_HOLD, CORE_DELAY, FETCH_DELAY, DEBOUNCE_CYCLES) + 1);

  rst_state_e       state_q, state_d;
  rst_cause_e       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             restart;
  logic             ext_level;
  logic             ext_hold;
  logic             lock_sync;
  logic             hold;

  // Board reset: synchronised and debounced; idles high (button released).
  rst_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .CYCLES      (DEBOUNCE_CYCLES),
    .RESET_VAL   (1'b1)
  ) u_ext_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (ext_rst_ni),
    .level_o (ext_level)
  );

  // Clock lock: synchronised only, assumed unlocked out of reset.
  rst_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .CYCLES      (0),
    .RESET_VAL   (1'b0)
  ) u_lock_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (clk_locked_i),
    .level_o (lock_sync)
  );

  assign ext_hold = ~ext_level;
  assign hold     = ext_hold | ~lock_sync;

  // Next state and cause: hold wins over a software request, lock over ext.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    restart = 1'b0;
    if (hold) begin
      state_d = ST_WAIT_LOCK;
      if (state_q != ST_WAIT_LOCK) begin
        cause_d = lock_sync ? CAUSE_EXT : CAUSE_LOCK;
      end
    end else if (sw_rst_req_i && (state_q != ST_WAIT_LOCK)) begin
      state_d = ST_HOLD_ALL;
      cause_d = CAUSE_SW;
      restart = 1'b1;
    end else begin
      case (state_q)
        ST_WAIT_LOCK:  state_d = ST_HOLD_ALL;
        ST_HOLD_ALL:   if (cnt_q == CNT_W'(PERIPH_HOLD - 1)) state_d = ST_REL_PERIPH;
        ST_REL_PERIPH: if (cnt_q == CNT_W'(CORE_DELAY - 1))  state_d = ST_REL_CORE;
        ST_REL_CORE:   if (cnt_q == CNT_W'(FETCH_DELAY - 1)) state_d = ST_RUN;
        ST_RUN:        state_d = ST_RUN;
        default:       state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  // Shared delay counter: clears on any state change or software restart.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || restart) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, counter and cause registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Moore output decode from the state register.
  always_comb begin
    rstn_periph_o  = 1'b0;
    rstn_core_o    = 1'b0;
    fetch_enable_o = 1'b0;
    case (state_q)
      ST_REL_PERIPH: begin
        rstn_periph_o = 1'b1;
      end
      ST_REL_CORE: begin
        rstn_periph_o = 1'b1;
        rstn_core_o   = 1'b1;
      end
      ST_RUN: begin
        rstn_periph_o  = 1'b1;
        rstn_core_o    = 1'b1;
        fetch_enable_o = 1'b1;
      end
      default: begin
        rstn_periph_o  = 1'b0;
        rstn_core_o    = 1'b0;
        fetch_enable_o = 1'b0;
      end
    endcase
  end

  assign busy_o      = (state_q != ST_RUN);
  assign rst_cause_o = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_pulpino_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulpino_rst_seq
// Description : Self-checking bench for pulpino_rst_seq. Expected output
//               snapshots are queued with a due cycle when stimulus is
//               driven and compared when that cycle is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulpino_rst_seq;

  logic       clk;
  logic       rst;
  logic       ext_rst_n;
  logic       clk_locked;
  logic       sw_rst_req;
  logic       rstn_periph;
  logic       rstn_core;
  logic       fetch_enable;
  logic [1:0] rst_cause;
  logic       busy;

  // {periph, core, fetch, busy}
  localparam logic [3:0] P_RST  = 4'b0001;
  localparam logic [3:0] P_PER  = 4'b1001;
  localparam logic [3:0] P_CORE = 4'b1101;
  localparam logic [3:0] P_RUN  = 4'b1110;

  typedef struct {
    int          due;
    logic [5:0]  exp;
    string       name;
  } exp_t;

  typedef struct {
    int          edge_n;
    logic [5:0]  exp;
  } vec_t;

  exp_t sb_q[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  pulpino_rst_seq #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16),
    .PERIPH_HOLD     (32),
    .CORE_DELAY      (16),
    .FETCH_DELAY     (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ext_rst_ni     (ext_rst_n),
    .clk_locked_i   (clk_locked),
    .sw_rst_req_i   (sw_rst_req),
    .rstn_periph_o  (rstn_periph),
    .rstn_core_o    (rstn_core),
    .fetch_enable_o (fetch_enable),
    .rst_cause_o    (rst_cause),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare every entry whose due cycle has been reached.
  always @(negedge clk) begin
    exp_t       e;
    logic [5:0] act;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e   = sb_q.pop_front();
      act = {rstn_periph, rstn_core, fetch_enable, busy, rst_cause};
      n_checks = n_checks + 1;
      if (act === e.exp) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL %s @cyc %0d: got p/c/f/b/cause=%b, expected %b",
                 e.name, cyc, act, e.exp);
      end
    end
  end

  // Queue an expectation 'delta' posedges from now, keeping due order.
  task automatic exp_push(input int delta, input logic [3:0] p,
                          input logic [1:0] cause, input string nm);
    exp_t e;
    int   i;
    e.due  = cyc + delta;
    e.exp  = {p, cause};
    e.name = nm;
    i = 0;
    while (i < sb_q.size() && sb_q[i].due <= e.due) i++;
    sb_q.insert(i, e);
  endtask

  // Compare the current outputs immediately.
  task automatic check_now(input logic [3:0] p, input logic [1:0] cause,
                           input string nm);
    logic [5:0] act;
    act = {rstn_periph, rstn_core, fetch_enable, busy, rst_cause};
    n_checks = n_checks + 1;
    if (act === {p, cause}) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s @cyc %0d: got p/c/f/b/cause=%b, expected %b",
               nm, cyc, act, {p, cause});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t pu_tbl[7];

    n_checks = 0;
    n_pass   = 0;

    // Power-up snapshots, indexed from edge 0 = first edge sampling rst=0.
    pu_tbl[0] = '{edge_n: 2,  exp: {P_RST,  2'd0}};
    pu_tbl[1] = '{edge_n: 34, exp: {P_RST,  2'd0}};
    pu_tbl[2] = '{edge_n: 35, exp: {P_PER,  2'd0}};
    pu_tbl[3] = '{edge_n: 50, exp: {P_PER,  2'd0}};
    pu_tbl[4] = '{edge_n: 51, exp: {P_CORE, 2'd0}};
    pu_tbl[5] = '{edge_n: 58, exp: {P_CORE, 2'd0}};
    pu_tbl[6] = '{edge_n: 59, exp: {P_RUN,  2'd0}};

    rst        = 1'b1;
    ext_rst_n  = 1'b1;
    clk_locked = 1'b1;
    sw_rst_req = 1'b0;

    // Reset state
    tick(3);
    check_now(P_RST, 2'd0, "reset_state_now");
    exp_push(1, P_RST, 2'd0, "reset_state");
    tick(2);

    // Power-up release
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_push(pu_tbl[i].edge_n + 1, pu_tbl[i].exp[5:2], pu_tbl[i].exp[1:0],
               $sformatf("pwrup_edge%0d", pu_tbl[i].edge_n));
    end
    tick(62);
    check_now(P_RUN, 2'd0, "pwrup_run_now");

    // Board glitch shorter than the debounce window
    ext_rst_n = 1'b0;
    exp_push(19, P_RUN, 2'd0, "glitch_no_effect_19");
    exp_push(25, P_RUN, 2'd0, "glitch_no_effect_25");
    tick(10);
    ext_rst_n = 1'b1;
    tick(20);
    check_now(P_RUN, 2'd0, "glitch_settled_now");

    // Board reset held 40 cycles
    ext_rst_n = 1'b0;
    exp_push(18, P_RUN, 2'd0, "ext_before_drop");
    exp_push(19, P_RST, 2'd1, "ext_drop");
    tick(40);
    check_now(P_RST, 2'd1, "ext_held_now");
    ext_rst_n = 1'b1;
    exp_push(18, P_RST, 2'd1, "ext_rel_waitlock");
    exp_push(50, P_RST, 2'd1, "ext_rel_hold_end");
    exp_push(51, P_PER, 2'd1, "ext_rel_periph");
    exp_push(75, P_RUN, 2'd1, "ext_rel_run");
    tick(80);

    // Lock loss for 5 cycles
    clk_locked = 1'b0;
    exp_push(2, P_RUN, 2'd1, "lock_before_drop");
    exp_push(3, P_RST, 2'd2, "lock_drop");
    tick(5);
    clk_locked = 1'b1;
    exp_push(34, P_RST, 2'd2, "lock_rel_hold_end");
    exp_push(35, P_PER, 2'd2, "lock_rel_periph");
    exp_push(59, P_RUN, 2'd2, "lock_rel_run");
    tick(62);
    check_now(P_RUN, 2'd2, "lock_run_now");

    // Software reset, with a second pulse during HOLD_ALL
    sw_rst_req = 1'b1;
    exp_push(1,  P_RST, 2'd3, "sw_drop");
    exp_push(33, P_RST, 2'd3, "sw_restart_hold");
    exp_push(42, P_RST, 2'd3, "sw_restart_hold_end");
    exp_push(43, P_PER, 2'd3, "sw_restart_periph");
    exp_push(67, P_RUN, 2'd3, "sw_run");
    tick(1);
    sw_rst_req = 1'b0;
    tick(9);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(60);

    // Sw pulse coincident with lock_sync fall, then sw in WAIT_LOCK
    clk_locked = 1'b0;
    exp_push(3,  P_RST,  2'd2, "simul_lock_wins");
    exp_push(8,  P_RST,  2'd2, "sw_ignored_waitlock");
    exp_push(63, P_CORE, 2'd2, "simul_rel_core");
    exp_push(64, P_RUN,  2'd2, "simul_run");
    tick(2);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(2);
    clk_locked = 1'b1;
    tick(2);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(58);

    // rst asserted in REL_CORE
    sw_rst_req = 1'b1;
    exp_push(1,   P_RST,  2'd3, "mid_sw_drop");
    exp_push(52,  P_CORE, 2'd3, "mid_in_rel_core");
    exp_push(53,  P_RST,  2'd0, "mid_reset_values");
    exp_push(114, P_CORE, 2'd0, "mid_repwr_core");
    exp_push(115, P_RUN,  2'd0, "mid_repwr_run");
    tick(1);
    sw_rst_req = 1'b0;
    tick(51);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(65);

    // Anything still queued was never compared.
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks = n_checks + 1;
      $display("FAIL %s: not compared by cyc %0d, expected due %0d", e.name, cyc, e.due);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
